// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4-lite memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: idle/grant, read address, read data, write addr+data, write response
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Anything other than OKAY is reported to the requester as an error
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pure combinational pick; the caller owns the last_grant register
    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (0) and load/store (1)
// onto a single AXI4-lite master port, one transaction in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp
);

    arb_state_e  state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic [1:0]  resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        grant_valid;
    logic        grant_idx;
    logic        accept;
    logic        aw_done;
    logic        w_done;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    rr_arbiter2 u_rr_arbiter2 (
        .req_valid   (req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign accept = (state_q == ST_IDLE) && grant_valid;

    // Request fields of the winning requester
    assign sel_we    = grant_idx ? req_we[1]          : req_we[0];
    assign sel_addr  = grant_idx ? req_addr[63:32]    : req_addr[31:0];
    assign sel_wdata = grant_idx ? req_wdata[63:32]   : req_wdata[31:0];
    assign sel_wstrb = grant_idx ? req_wstrb[7:4]     : req_wstrb[3:0];

    // A channel counts as done once it has handshaked, including this cycle
    assign aw_done = !awvalid_q || axi_awready;
    assign w_done  = !wvalid_q  || axi_wready;

    // Acceptance strobe is combinational so the requester sees it in the grant cycle;
    // gating with rst_n keeps it low for the whole reset, not just after an edge
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Transaction FSM with all AXI and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        wstrb_q      <= sel_wstrb;
                        if (sel_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_AWW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi_rvalid) begin
                        rready_q            <= 1'b0;
                        resp_rdata_q        <= axi_rdata;
                        resp_err_q          <= resp_is_err(axi_rresp);
                        resp_valid_q[gnt_q] <= 1'b1;
                        state_q             <= ST_IDLE;
                    end
                end
                ST_AWW: begin
                    if (awvalid_q && axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi_bvalid) begin
                        bready_q            <= 1'b0;
                        resp_rdata_q        <= '0;
                        resp_err_q          <= resp_is_err(axi_bresp);
                        resp_valid_q[gnt_q] <= 1'b1;
                        state_q             <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_arprot  = AXI_PROT_DEFAULT;
    assign axi_rready  = rready_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awprot  = AXI_PROT_DEFAULT;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_bready  = bready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; arbitration is fixed round-robin between requester 0 (instruction fetch) and requester 1 (execute load/store).
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  2  per-requester request pending.
REQ-005 req_ready  out  2  per-requester acceptance strobe.
REQ-006 req_we  in  2  per-requester: 1=write, 0=read.
REQ-007 req_addr  in  64  requester i byte address at [32*i+:32].
REQ-008 req_wdata  in  64  requester i write data at [32*i+:32].
REQ-009 req_wstrb  in  8  requester i byte strobes at [4*i+:4].
REQ-010 resp_valid  out  2  per-requester one-cycle completion pulse.
REQ-011 resp_rdata  out  32  read data, shared, valid with resp_valid.
REQ-012 resp_err  out  1  1 when AXI response was not OKAY, valid with resp_valid.
REQ-013 axi_awvalid / axi_awready  out / in  1 / 1  AXI4-lite write-address handshake.
REQ-014 axi_awaddr  out  32  write address.
REQ-015 axi_awprot  out  3  constant 3'b000.
REQ-016 axi_wvalid / axi_wready  out / in  1 / 1  write-data handshake.
REQ-017 axi_wdata  out  32  write data.
REQ-018 axi_wstrb  out  4  write strobes.
REQ-019 axi_bvalid / axi_bready  in / out  1 / 1  write-response handshake.
REQ-020 axi_bresp  in  2  write response.
REQ-021 axi_arvalid / axi_arready  out / in  1 / 1  read-address handshake.
REQ-022 axi_araddr  out  32  read address.
REQ-023 axi_arprot  out  3  constant 3'b000.
REQ-024 axi_rvalid / axi_rready  in / out  1 / 1  read-data handshake.
REQ-025 axi_rdata  in  32  read data.
REQ-026 axi_rresp  in  2  read response.

Function
REQ-027 FSM states IDLE, AR, R, AWW, B; exactly one transaction outstanding; req_ready is 0 outside IDLE.
REQ-028 IDLE: if any req_valid, grant g (single requester -> it; both -> index != last_grant), assert req_ready[g] that cycle, latch addr/wdata/wstrb/we of g, last_grant<=g, go to AR (read) or AWW (write).
REQ-029 axi_arvalid, or axi_awvalid+axi_wvalid together, assert the cycle after acceptance, driven from latched registers, stable until handshaked.
REQ-030 AR: hold arvalid until arready; then R with rready=1. R: on rvalid, capture rdata, err=(rresp!=0), rready<=0, go IDLE.
REQ-031 AWW: awvalid and wvalid each drop independently on their own handshake (same-cycle handshakes allowed); when both done go B with bready=1.
REQ-032 B: on bvalid, err=(bresp!=0), resp_rdata<=0, bready<=0, go IDLE.
REQ-033 resp_valid[g] is a registered pulse of exactly one cycle, the first IDLE cycle after completion; a new request may be accepted in that same cycle.
REQ-034 Withdrawing req_valid before acceptance is legal; no AXI activity results.
REQ-035 Minimum read latency, zero-wait slave: accept cycle 0, arvalid cycle 1, rvalid cycle 2, resp_valid cycle 3.

Reset
REQ-036 rst_n low: state=IDLE, last_grant=1 (requester 0 wins first tie), every valid/ready/resp output, resp_rdata and resp_err 0 immediately, including mid-transaction.

Structure
REQ-037 FSM state enum and AXI response codes (OKAY=2'b00) belong in the shared core package.
REQ-038 One sub-module is natural: rr_arbiter2 (2-way round-robin grant from req_valid and last_grant).

Verification
REQ-039 Req0 read 0x100, arready same cycle, rdata 0xDEADBEEF, rresp 0 -> araddr 0x100, resp_valid=2'b01 cycle 3, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-040 Both requesters hold read requests continuously -> grants 0,1,0,1; never two consecutive grants to one requester.
REQ-041 Req1 write 0x2000/0x12345678/wstrb 4'b0011, wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, bready only after both, resp_valid=2'b10.
REQ-042 Write with bresp=2'b10 -> resp_err=1 with resp_valid; read with rresp=2'b11 -> resp_err=1.
REQ-043 rst_n low while in R -> all outputs 0 same cycle; after release, req1 read completes normally and req0 wins a tie.
